// File: rtl/pcm_i2s_tx.sv
// Mono PCM to Philips I2S transmitter: sample FIFO, BCLK divider, 32-slot framer, sticky flags.
// Latency: sample leaves at the next frame load (slot 0->1 fall); samples that find the FIFO full are dropped and flagged.
module pcm_i2s_tx #(
    parameter int CLK_DIV = 8,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                x_in,
    input  logic                       x_in_valid,
    input  logic                       flag_clr,
    output logic                       bclk,
    output logic                       lrclk,
    output logic                       sdata,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       underflow,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] div_cnt;
    logic [4:0]    slot;
    logic [4:0]    slot_nxt;
    logic [31:0]   frame;
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [15:0]   head;
    logic          fall_evt;
    logic          load;
    logic          pop;
    logic          push;
    logic          drop;

    always_comb begin
        slot_nxt = slot + 5'd1;
        head     = mem[rd_ptr];
        fall_evt = (div_cnt == DIV_LAST) && bclk;
        load     = fall_evt && (slot == 5'd0);
        pop      = load && (fifo_count != '0);
        // A pop in the same cycle frees the slot the push needs.
        push     = x_in_valid && ((fifo_count < FULL_CNT) || pop);
        drop     = x_in_valid && !push;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= x_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            bclk       <= 1'b0;
            lrclk      <= 1'b0;
            sdata      <= 1'b0;
            slot       <= '0;
            frame      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            underflow  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end

            if (fall_evt) begin
                slot  <= slot_nxt;
                lrclk <= slot_nxt[4];
                if (load) begin
                    // MSB goes out now; the rest of {S,S} waits pre-shifted.
                    if (pop) begin
                        sdata <= head[15];
                        frame <= {head[14:0], head, 1'b0};
                    end else begin
                        sdata <= 1'b0;
                        frame <= '0;
                    end
                end else begin
                    sdata <= frame[31];
                    frame <= {frame[30:0], 1'b0};
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + (AW + 1)'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - (AW + 1)'(1);
            end

            if (load && (fifo_count == '0)) begin
                underflow <= 1'b1;
            end else if (flag_clr) begin
                underflow <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (flag_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pcm_i2s_tx.md
# pcm_i2s_tx

Output stage of the decimation chain. Buffers mono 16-bit PCM samples from the final halfband decimator (`y_out` / `y_out_valid`) in a small FIFO. Serializes each sample onto both channels of a Philips-format I2S link (BCLK, LRCLK, SDATA) for the DAC/codec. Also derives the I2S bit clock from the system clock and reports FIFO underflow and overflow.

## Interface
Parameters:
- `CLK_DIV`, default 8: `clk` cycles per BCLK half-period, ≥2. BCLK = f_clk / (2·CLK_DIV).
- `DEPTH`, default 8: FIFO depth in samples, power of two, ≥2.

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `x_in` in 16: signed Q15 sample, connected to the decimator's `y_out`.
- `x_in_valid` in 1: one-cycle strobe; push `x_in` into the FIFO.
- `flag_clr` in 1: clears the sticky `underflow` and `overflow` flags.
- `bclk` out 1: I2S bit clock (registered).
- `lrclk` out 1: word select; 0 = left, 1 = right (registered).
- `sdata` out 1: serial data, MSB first (registered).
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `underflow` out 1: sticky; a frame started with the FIFO empty.
- `overflow` out 1: sticky; a sample was dropped because the FIFO was full.

## Operation
- **Clock divider.**
  - `div_cnt` counts 0..CLK_DIV-1.
  - When it reaches CLK_DIV-1, `bclk` toggles and `div_cnt` returns to 0.
  - A toggle 1→0 is a "fall event"; a toggle 0→1 is a "rise event".
- **Slot counter.**
  - 5-bit `slot`, 0..31, advances by one on each fall event and wraps 31→0.
  - `lrclk` = 0 for slots 0–15 and 1 for slots 16–31.
  - `lrclk` updates in the same clk cycle as `bclk` falls.
- **Frame load.** On the fall event that moves `slot` from 0→1:
  - FIFO non-empty: pop the head sample S and load the 32-bit frame {S, S} (left, then right).
  - FIFO empty: load 32'h0 and set `underflow`.
- **Serialization.**
  - Each fall event drives `sdata` with the next frame bit, MSB first.
  - Slots 1–16 carry left bits 15..0.
  - Slots 17–31 carry right bits 15..1.
  - Slot 0 of the following frame carries right bit 0.
  - This is the standard one-BCLK I2S delay. `sdata` is stable across the BCLK rise event.
- **FIFO.**
  - Circular buffer with read/write pointers and a count.
  - A push is accepted when `fifo_count < DEPTH`, or when a pop occurs in the same cycle.
  - A push that is not accepted drops the sample and sets `overflow`; FIFO contents are unchanged.
  - Simultaneous push and pop leaves `fifo_count` unchanged.
  - Pointers wrap modulo DEPTH.
- **Flags.**
  - `underflow` and `overflow` are set by their events and cleared only by `flag_clr` or `reset`.
  - If a set event and `flag_clr` occur in the same cycle, set wins.
- **Arithmetic.** Samples pass through bit-exact: no scaling, no rounding, no sign manipulation.

## Timing
- **Reset** (synchronous; takes effect at the clk edge where `reset` = 1):
  - `bclk`=0, `lrclk`=0, `sdata`=0, `fifo_count`=0, `underflow`=0, `overflow`=0.
  - `div_cnt`=0, `slot`=0, frame register = 0, FIFO emptied.
- **Reset mid-frame:** abandons the frame immediately with no partial-frame completion. Every output reaches its reset value at the next edge.
- **After reset release:**
  - First rise event at clk cycle CLK_DIV.
  - First fall event, and the first frame load, at cycle 2·CLK_DIV.
  - A frame is 64·CLK_DIV clk cycles long.
- **Push visibility:** `fifo_count` reflects a push one cycle after the `x_in_valid` strobe.
- **Latency:** the MSB of a sample appears on `sdata` at the first 0→1 slot fall event that occurs when the sample is at the FIFO head. A sample pushed into an empty FIFO at least one cycle before that event is sent in that frame.
- **Registered outputs:** `bclk`, `lrclk` and `sdata` change together, in the same clk cycle.
- **Input rate:** `x_in_valid` may assert on any cycle, including back-to-back cycles.

## Test plan
- **Single sample** (CLK_DIV=4): push 16'hA5C3 after reset. Expect on `sdata` over slots 1–16, sampled on `bclk` rising: 1010 0101 1100 0011. Expect slots 17–31 plus the next slot 0 to carry the same 16 bits. Expect `lrclk` rising at the slot-16 fall and `underflow`=0.
- **Underflow:** no pushes after reset. Expect all `sdata` = 0 and `underflow`=1 after the cycle-8 fall event (CLK_DIV=4). Pulse `flag_clr`; expect `underflow` = 0, then 1 again at the next frame load.
- **Overflow:** push 9 back-to-back samples (1..9) with no frame load in that window. Expect `fifo_count`=8 and `overflow`=1. Over the next 8 frames expect samples 1..8 in order and sample 9 never transmitted.
- **Simultaneous push/pop:** FIFO full (8). Strobe `x_in_valid` in the exact cycle of a frame load. Expect the sample accepted, `fifo_count` still 8, `overflow`=0.
- **Sign and extremes:** push 16'h8000, then 16'h7FFF, then 16'hFFFF. Expect the exact bit patterns on both channels, MSB first, in three consecutive frames.
- **Reset mid-frame:** assert `reset` for 1 cycle at slot 10. Expect all outputs at reset values the next cycle, FIFO empty, and the first post-reset rise at cycle CLK_DIV.
